clk_period_meter: RTL and testbench

- Measures a slow clock-like input, such as a divided clock or PWM output, in units of the system clock.
- Synchronises the input, detects its edges, and reports period and high time as i_clk cycle counts.
- Single-shot, started by a one-cycle strobe; signals done or timeout.
- Used as the self-check partner of the clock dividers and PWM generators.

---
 rtl/clk_period_meter.sv | 179 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: single-shot measurement of the period and high time of a
// slow, asynchronous clock-like input, counted in i_clk cycles.
module clk_period_meter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_meas_clk,
   input  logic             i_start,
   output logic             o_busy,
   output logic             o_valid,
   output logic             o_timeout,
   output logic [WIDTH-1:0] o_period,
   output logic [WIDTH-1:0] o_high
);

   // Counter limits: the period counter saturates at all-ones, the edge wait
   // aborts when the wait count is about to reach TIMEOUT.
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] WAIT_END = WIDTH'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic             dly_q;
   logic             meas_s;
   logic             rise_p;
   logic             fall_p;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] wait_q, wait_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] wait_inc;
   logic             wait_end;
   logic             busy_d;
   logic             valid_d;
   logic             timeout_d;
   logic [WIDTH-1:0] period_d;
   logic [WIDTH-1:0] high_out_d;

   // Two-flop synchroniser followed by a delay flop for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= 2'b00;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], i_meas_clk};
         dly_q  <= sync_q[1];
      end
   end

   // Single-cycle pulses, one per synchronised edge.
   assign meas_s = sync_q[1];
   assign rise_p = meas_s & ~dly_q;
   assign fall_p = ~meas_s & dly_q;

   // Saturating increments and the abort condition for the edge wait.
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WIDTH'(1);
   assign wait_inc = wait_q + WIDTH'(1);
   assign wait_end = (wait_q == WAIT_END);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wait_d     = wait_q;
      high_d     = high_q;
      valid_d    = 1'b0;
      timeout_d  = 1'b0;
      period_d   = o_period;
      high_out_d = o_high;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_ARM;
               cnt_d   = '0;
               wait_d  = '0;
            end
         end

         // Waiting for a full rising edge; a level already high is ignored.
         S_ARM: begin
            if (rise_p) begin
               state_d = S_HIGH;
               cnt_d   = WIDTH'(1);
               wait_d  = '0;
            end else if (wait_end) begin
               state_d    = S_IDLE;
               timeout_d  = 1'b1;
               period_d   = '0;
               high_out_d = '0;
            end else begin
               wait_d = wait_inc;
            end
         end

         // High phase: counter keeps running, capture high time on the fall.
         S_HIGH: begin
            cnt_d = cnt_inc;
            if (fall_p) begin
               state_d = S_LOW;
               high_d  = cnt_q;
               wait_d  = '0;
            end else if (wait_end) begin
               state_d    = S_IDLE;
               timeout_d  = 1'b1;
               period_d   = '0;
               high_out_d = '0;
            end else begin
               wait_d = wait_inc;
            end
         end

         // Low phase: the next rise closes the period and publishes results.
         S_LOW: begin
            cnt_d = cnt_inc;
            if (rise_p) begin
               state_d    = S_DONE;
               period_d   = cnt_q;
               high_out_d = high_q;
               valid_d    = 1'b1;
               wait_d     = '0;
            end else if (wait_end) begin
               state_d    = S_IDLE;
               timeout_d  = 1'b1;
               period_d   = '0;
               high_out_d = '0;
            end else begin
               wait_d = wait_inc;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_HIGH) || (state_d == S_LOW);
   end

   // State, counters and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wait_q    <= '0;
         high_q    <= '0;
         o_busy    <= 1'b0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         o_period  <= '0;
         o_high    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
         high_q    <= high_d;
         o_busy    <= busy_d;
         o_valid   <= valid_d;
         o_timeout <= timeout_d;
         o_period  <= period_d;
         o_high    <= high_out_d;
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: periodic sources with known high
// and low times, timeout, partial pulse at start, reset mid-measurement and
// counter saturation on a narrow instance.
module tb_clk_period_meter;

   localparam int unsigned W   = 16;
   localparam int unsigned TO  = 100;
   localparam int unsigned W2  = 4;
   localparam int unsigned TO2 = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          meas = 1'b0;
   logic          start = 1'b0;
   logic          start2 = 1'b0;
   logic          busy, valid, tout;
   logic [W-1:0]  period, high;
   logic          busy2, valid2, tout2;
   logic [W2-1:0] period2, high2;

   int n_cmp = 0;
   int n_err = 0;

   // Source waveform: 0 stuck low, 1 periodic, 2 stuck high.
   int src_mode = 0;
   int src_h = 2;
   int src_l = 2;

   clk_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_meas_clk(meas), .i_start(start),
      .o_busy(busy), .o_valid(valid), .o_timeout(tout),
      .o_period(period), .o_high(high)
   );

   clk_period_meter #(.WIDTH(W2), .TIMEOUT(TO2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_meas_clk(meas), .i_start(start2),
      .o_busy(busy2), .o_valid(valid2), .o_timeout(tout2),
      .o_period(period2), .o_high(high2)
   );

   always #5 clk = ~clk;

   // Source generator, changing only on falling clock edges.
   initial begin : src_gen
      forever begin
         if (src_mode == 1) begin
            meas = 1'b1;
            repeat (src_h) @(negedge clk);
            meas = 1'b0;
            repeat (src_l) @(negedge clk);
         end else begin
            meas = (src_mode == 2);
            @(negedge clk);
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Reference: period is high+low time, clipped at the counter maximum.
   function automatic int exp_val(input int cycles, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (cycles > mx) ? mx : cycles;
   endfunction

   task automatic set_source(input int mode, input int h, input int l);
      src_mode = mode;
      src_h = h;
      src_l = l;
      repeat (200) @(negedge clk);
   endtask

   task automatic wait_meas(input logic v, input string tag);
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk);
         if (meas === v) hit = 1;
      end
      n_cmp++;
      if (!hit) begin
         n_err++;
         $display("FAIL %s: source level %0b not seen within 200 cycles", tag, v);
      end
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
   endtask

   // Start one measurement and check the single result against the model.
   task automatic run_measure(input bit sel, input int h, input int l, input string tag);
      int w, exp_p, exp_h;
      bit got = 0;
      logic prev_busy, vld, bsy, to;
      logic [W-1:0] p, hh;
      w = sel ? W2 : W;
      exp_p = exp_val(h + l, w);
      exp_h = exp_val(h, w);
      pulse_start(sel);
      bsy = sel ? busy2 : busy;
      n_cmp++;
      if (bsy !== 1'b1) begin
         n_err++;
         $display("FAIL %s_busy_after_start: got %b want 1", tag, bsy);
      end
      prev_busy = bsy;
      for (int i = 0; i < 400 && !got; i++) begin
         vld = sel ? valid2 : valid;
         bsy = sel ? busy2 : busy;
         to  = sel ? tout2 : tout;
         p   = sel ? W'(period2) : period;
         hh  = sel ? W'(high2) : high;
         if (to === 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL %s_unexpected_timeout: got 1 want 0", tag);
         end
         if (vld === 1'b1) begin
            got = 1;
            n_cmp++;
            if (p !== W'(exp_p)) begin
               n_err++;
               $display("FAIL %s_period: got %0d want %0d", tag, p, exp_p);
            end
            n_cmp++;
            if (hh !== W'(exp_h)) begin
               n_err++;
               $display("FAIL %s_high: got %0d want %0d", tag, hh, exp_h);
            end
            n_cmp++;
            if (bsy !== 1'b0 || prev_busy !== 1'b1) begin
               n_err++;
               $display("FAIL %s_busy_fall: got busy=%b prev=%b want 0/1", tag, bsy, prev_busy);
            end
         end
         prev_busy = bsy;
         @(negedge clk);
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL %s_no_valid: got none want one pulse within 400 cycles", tag);
      end
      vld = sel ? valid2 : valid;
      p   = sel ? W'(period2) : period;
      n_cmp++;
      if (vld !== 1'b0 || p !== W'(exp_p)) begin
         n_err++;
         $display("FAIL %s_pulse_hold: got valid=%b period=%0d want 0/%0d", tag, vld, p, exp_p);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, valid, tout, period, high} !== '0) begin
         n_err++;
         $display("FAIL reset_in: got b=%b v=%b t=%b p=%0d h=%0d want all 0",
                  busy, valid, tout, period, high);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({busy, valid, tout, period, high} !== '0) begin
         n_err++;
         $display("FAIL reset_idle: got b=%b v=%b t=%b p=%0d h=%0d want all 0",
                  busy, valid, tout, period, high);
      end
   endtask

   task automatic test_div4();
      set_source(1, 2, 2);
      run_measure(0, 2, 2, "div4");
   endtask

   task automatic test_div64();
      set_source(1, 32, 32);
      run_measure(0, 32, 32, "div64_a");
      run_measure(0, 32, 32, "div64_b");
   endtask

   task automatic test_start_in_high();
      int valids = 0;
      set_source(1, 10, 30);
      wait_meas(1'b0, "sih_low");
      pulse_start(0);
      wait_meas(1'b1, "sih_rise");
      repeat (4) @(posedge clk);
      pulse_start(0);
      for (int i = 0; i < 300; i++) begin
         if (valid === 1'b1) begin
            valids++;
            n_cmp++;
            if (period !== W'(40) || high !== W'(10)) begin
               n_err++;
               $display("FAIL sih_result: got %0d/%0d want 40/10", period, high);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (valids != 1) begin
         n_err++;
         $display("FAIL sih_valid_count: got %0d want 1", valids);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL sih_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_timeout();
      int busy_cyc = 0;
      bit hit = 0;
      bit saw_valid = 0;
      set_source(0, 2, 2);
      pulse_start(0);
      for (int i = 0; i < 400 && !hit; i++) begin
         if (valid === 1'b1) saw_valid = 1;
         if (tout === 1'b1) begin
            hit = 1;
            n_cmp++;
            if (busy_cyc != int'(TO)) begin
               n_err++;
               $display("FAIL to_latency: got %0d want %0d", busy_cyc, TO);
            end
            n_cmp++;
            if (period !== '0 || high !== '0 || busy !== 1'b0) begin
               n_err++;
               $display("FAIL to_outputs: got p=%0d h=%0d b=%b want 0/0/0", period, high, busy);
            end
         end else if (busy === 1'b1) begin
            busy_cyc++;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!hit || saw_valid) begin
         n_err++;
         $display("FAIL to_pulse: got timeout=%0b valid_seen=%0b want 1/0", hit, saw_valid);
      end
      n_cmp++;
      if (tout !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL to_after: got t=%b b=%b v=%b want 0/0/0", tout, busy, valid);
      end
   endtask

   task automatic test_partial_high();
      set_source(1, 5, 15);
      wait_meas(1'b0, "part_low");
      wait_meas(1'b1, "part_rise");
      repeat (2) @(posedge clk);
      run_measure(0, 5, 15, "partial");
   endtask

   task automatic test_reset_mid();
      set_source(1, 10, 30);
      wait_meas(1'b0, "rst_low");
      pulse_start(0);
      wait_meas(1'b1, "rst_rise");
      wait_meas(1'b0, "rst_fall");
      repeat (8) @(posedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_busy_before: got %b want 1", busy);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, valid, tout, period, high} !== '0) begin
         n_err++;
         $display("FAIL rst_async: got b=%b v=%b t=%b p=%0d h=%0d want all 0",
                  busy, valid, tout, period, high);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid !== 1'b0 || tout !== 1'b0 || busy !== 1'b0) begin
            n_cmp++; n_err++;
            $display("FAIL rst_after: got v=%b t=%b b=%b want 0/0/0", valid, tout, busy);
         end
      end
      set_source(1, 2, 2);
      run_measure(0, 2, 2, "rst_div4");
   endtask

   task automatic test_random();
      int h, l;
      for (int k = 0; k < 6; k++) begin
         h = $urandom_range(40, 2);
         l = $urandom_range(40, 2);
         set_source(1, h, l);
         run_measure(0, h, l, $sformatf("rand%0d_%0d_%0d", k, h, l));
      end
   endtask

   task automatic test_saturation();
      set_source(1, 10, 10);
      run_measure(1, 10, 10, "sat");
   endtask

   initial begin : main
      test_reset();
      test_div4();
      test_div64();
      test_start_in_high();
      test_timeout();
      test_partial_high();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
